// File: rtl/gpio_regs_pkg.sv
// Shared constants, types and helpers for the Wishbone GPIO responder.
package gpio_regs_pkg;

  localparam int N_IO = 38;
  localparam int N_HI = 6;

  // Word offsets within the 256-byte window (byte address bits [7:2]).
  localparam logic [5:0] OFS_OUT_LO = 6'h00;
  localparam logic [5:0] OFS_OUT_HI = 6'h01;
  localparam logic [5:0] OFS_OEB_LO = 6'h02;
  localparam logic [5:0] OFS_OEB_HI = 6'h03;
  localparam logic [5:0] OFS_IN_LO  = 6'h04;
  localparam logic [5:0] OFS_IN_HI  = 6'h05;
  localparam logic [5:0] OFS_STAT   = 6'h06;
  localparam logic [5:0] OFS_IRQ_EN = 6'h07;

  // All pads come out of reset as inputs.
  localparam logic [31:0]     OEB_LO_RST = 32'hFFFF_FFFF;
  localparam logic [N_HI-1:0] OEB_HI_RST = {N_HI{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_state_t;

  // Expand the four byte-lane selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Multi-stage synchronizer for asynchronous pad inputs, plus one extra
// flop of history so single-cycle rising-edge pulses can be derived.
module gpio_in_sync #(
  parameter int WIDTH  = 38,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  // Shift the pad values through the synchronizer chain and keep one cycle of history.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // old value on the same edge; blocking ones would collapse the chain.
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign sync = stage_q[STAGES-1];
  assign rise = sync & ~prev_q;

endmodule

// File: rtl/wb_gpio_responder.sv
// Wishbone B4 classic responder exposing the user IO pads as registers:
// output value, output enable, synchronized input and rising-edge IRQ.
module wb_gpio_responder
  import gpio_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [N_IO-1:0]  io_in,
  output logic [N_IO-1:0]  io_out,
  output logic [N_IO-1:0]  io_oeb,
  output logic [2:0]       user_irq
);

  wb_state_t state_q, state_d;
  logic      hit, xfer, wr, rd;
  logic [5:0]  ofs;
  logic [31:0] wmask, rd_data, stat_clr;

  logic [31:0]     out_lo_q, oeb_lo_q, stat_q, irq_en_q, dat_q;
  logic [N_HI-1:0] out_hi_q, oeb_hi_q;
  logic            irq_q;

  logic [N_IO-1:0] sync, rise;

  // The byte offset's low bits and the upper-pin edges carry no function.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], rise[N_IO-1:32]};

  gpio_in_sync #(
    .WIDTH  (N_IO),
    .STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (io_in),
    .sync (sync),
    .rise (rise)
  );

  assign hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign ofs   = wbs_adr_i[7:2];
  assign wmask = lane_mask(wbs_sel_i);
  assign wr    = xfer & wbs_we_i;
  assign rd    = xfer & ~wbs_we_i;

  // Bus FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: accept a hit from IDLE, always fall back from ACK after one cycle.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: if (hit) begin
        state_d = ACK;
        xfer    = 1'b1;
      end
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writable control registers, merged per byte lane.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_lo_q <= '0;
      out_hi_q <= '0;
      oeb_lo_q <= OEB_LO_RST;
      oeb_hi_q <= OEB_HI_RST;
      irq_en_q <= '0;
    end else if (wr) begin
      case (ofs)
        OFS_OUT_LO: out_lo_q <= (out_lo_q & ~wmask) | (wbs_dat_i & wmask);
        OFS_OUT_HI: out_hi_q <= (out_hi_q & ~wmask[N_HI-1:0]) |
                                (wbs_dat_i[N_HI-1:0] & wmask[N_HI-1:0]);
        OFS_OEB_LO: oeb_lo_q <= (oeb_lo_q & ~wmask) | (wbs_dat_i & wmask);
        OFS_OEB_HI: oeb_hi_q <= (oeb_hi_q & ~wmask[N_HI-1:0]) |
                                (wbs_dat_i[N_HI-1:0] & wmask[N_HI-1:0]);
        OFS_IRQ_EN: irq_en_q <= (irq_en_q & ~wmask) | (wbs_dat_i & wmask);
        default: ;
      endcase
    end
  end

  // Write-one-to-clear mask for the edge status register.
  always_comb begin
    stat_clr = '0;
    if (wr && (ofs == OFS_STAT)) stat_clr = wbs_dat_i & wmask;
  end

  // Edge status: a new edge wins over a simultaneous clear of the same bit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) stat_q <= '0;
    else          stat_q <= (stat_q & ~stat_clr) | rise[31:0];
  end

  // Read data selection; unmapped offsets and unused bits read zero.
  always_comb begin
    rd_data = '0;
    case (ofs)
      OFS_OUT_LO: rd_data = out_lo_q;
      OFS_OUT_HI: rd_data[N_HI-1:0] = out_hi_q;
      OFS_OEB_LO: rd_data = oeb_lo_q;
      OFS_OEB_HI: rd_data[N_HI-1:0] = oeb_hi_q;
      OFS_IN_LO:  rd_data = sync[31:0];
      OFS_IN_HI:  rd_data[N_HI-1:0] = sync[N_IO-1:32];
      OFS_STAT:   rd_data = stat_q;
      OFS_IRQ_EN: rd_data = irq_en_q;
      default:    rd_data = '0;
    endcase
  end

  // Read data is captured on the accepting edge and held until the next read.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) dat_q <= '0;
    else if (rd)  dat_q <= rd_data;
  end

  // Interrupt lags the status/enable registers by one cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= |(stat_q & irq_en_q);
  end

  assign wbs_ack_o = (state_q == ACK);
  assign wbs_dat_o = dat_q;
  assign io_out    = {out_hi_q, out_lo_q};
  assign io_oeb    = {oeb_hi_q, oeb_lo_q};
  assign user_irq  = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_gpio_responder.sv
// Directed bench for wb_gpio_responder: a register-access vector table plus
// hand-timed sequences for ack width, edge/IRQ, clear/set collision and reset.
module tb_wb_gpio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_in, io_out, io_oeb;
  logic [2:0]  user_irq;

  int n_applied = 0;
  int n_miss    = 0;

  always #5 clk = ~clk;

  wb_gpio_responder dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .user_irq  (user_irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus transfer; waits at most 16 cycles for ack.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic acked, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0;
    rd    = '0;
    for (int i = 0; i < 16 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd    = rdat;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input string name);
    logic ok;
    logic [31:0] rd;
    bus_xfer(1'b1, a, d, 4'hF, ok, rd);
    check({name, "_ack"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic rd32(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic ok;
    logic [31:0] rd;
    bus_xfer(1'b0, a, 32'h0, 4'hF, ok, rd);
    check({name, "_ack"}, {63'd0, ok}, 64'd1);
    check(name, {32'd0, rd}, {32'd0, exp});
  endtask

  initial begin
    logic ok;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 1'b1, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 32'h3000_001C, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 32'h00A5_00A5};
    vecs[3]  = '{1'b1, 32'h3000_0100, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 32'h00A5_00A5};
    vecs[5]  = '{1'b1, 32'h3000_0040, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h3000_0040, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1'b1, 32'h0000_003F};
    vecs[9]  = '{1'b1, 32'h3000_000C, 32'h0000_0000, 4'hF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 32'h00A5_00A5};
    vecs[13] = '{1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 1'b1, 32'h0000_0000};
    vecs[15] = '{1'b0, 32'h3000_0007, 32'h0,         4'hF, 1'b1, 32'h0000_003F};
    vecs[16] = '{1'b1, 32'h3000_0008, 32'h1234_0000, 4'hC, 1'b1, 32'h0};
    vecs[17] = '{1'b0, 32'h3000_000B, 32'h0,         4'hF, 1'b1, 32'h1234_FFFF};

    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; wdat = '0; io_in = '0;

    // Reset for three cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_oeb", {26'd0, io_oeb}, {26'd0, 38'h3F_FFFF_FFFF});
    check("rst_out", {26'd0, io_out}, 64'd0);
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_irq", {61'd0, user_irq}, 64'd0);

    // Byte-lane write with stb held past the ack: single-cycle ack pulse.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000;
    wdat = 32'hA5A5_A5A5; sel = 4'b0101;
    @(posedge clk); #1;
    check("pulse_ack1", {63'd0, ack}, 64'd1);
    check("pulse_io_out", {32'd0, io_out[31:0]}, {32'd0, 32'h00A5_00A5});
    @(posedge clk); #1;
    check("pulse_ack2", {63'd0, ack}, 64'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;

    // Register-access vector table.
    for (int i = 0; i < NVEC; i++) begin
      bus_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, ok, rd);
      check($sformatf("vec%0d_ack", i), {63'd0, ok}, {63'd0, vecs[i].exp_ack});
      if (!vecs[i].we && vecs[i].exp_ack)
        check($sformatf("vec%0d_data", i), {32'd0, rd}, {32'd0, vecs[i].exp_rd});
    end
    check("tbl_io_out", {26'd0, io_out}, {26'd0, 38'h3F_00A5_00A5});
    check("tbl_io_oeb", {26'd0, io_oeb}, {26'd0, 38'h00_1234_FFFF});

    // Rising edge on io_in[3]: synchronized input, status and interrupt.
    io_in[3] = 1'b1;
    repeat (3) @(posedge clk);
    rd32(32'h3000_0010, 32'h0000_0008, "in_lo_bit3");
    rd32(32'h3000_0018, 32'h0000_0008, "stat_bit3");
    check("irq_disabled", {61'd0, user_irq}, 64'd0);
    wr32(32'h3000_001C, 32'h0000_0008, "irq_en_wr");
    check("irq_lag", {61'd0, user_irq}, 64'd0);
    @(posedge clk); #1;
    check("irq_set", {61'd0, user_irq}, 64'd1);
    wr32(32'h3000_0018, 32'h0000_0008, "stat_clr_wr");
    @(posedge clk); #1;
    check("irq_clr", {61'd0, user_irq}, 64'd0);
    rd32(32'h3000_0018, 32'h0000_0000, "stat_cleared");

    // Clear/set collision on STAT bit 5.
    io_in[5] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    io_in[5] = 1'b0;
    repeat (4) @(posedge clk);
    rd32(32'h3000_0018, 32'h0000_0020, "stat_bit5");
    io_in[5] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr32(32'h3000_0018, 32'h0000_0020, "collide_wr");
    rd32(32'h3000_0018, 32'h0000_0020, "collide_set_wins");
    wr32(32'h3000_0018, 32'h0000_0020, "plain_clr_wr");
    rd32(32'h3000_0018, 32'h0000_0000, "plain_clr");

    // Reset asserted the cycle before the ack edge of a write.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000;
    wdat = 32'h1234_5678; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", {63'd0, ack}, 64'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack2", {63'd0, ack}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_io_out", {26'd0, io_out}, 64'd0);
    check("midrst_io_oeb", {26'd0, io_oeb}, {26'd0, 38'h3F_FFFF_FFFF});
    rd32(32'h3000_0000, 32'h0000_0000, "midrst_out_lo");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_gpio_responder.md
Name: wb_gpio_responder

Overview:
- Wishbone B4 classic responder inside the user project area. It answers the management SoC's wbs_* bus.
- Exposes the 38 user IO pins as memory-mapped registers: output value, output-enable, synchronized input, and rising-edge interrupt status/enable.
- Drives io_out/io_oeb and user_irq[0]. Sits between the wrapper's wbs_* ports and the IO pads.

Parameters:
- BASE_ADR, 32'h3000_0000, bus address of register 0; the window is 256 bytes.
- SYNC_STAGES, 2, io_in synchronizer depth (>=2).

Ports:
- wb_clk_i  in  1  the single clock
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1=write
- wbs_sel_i  in  4  byte lane enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- io_in  in  38  pad inputs (asynchronous)
- io_out  out  38  pad output values
- io_oeb  out  38  pad output enable, active-low
- user_irq  out  3  interrupts to the SoC

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, io_out=0.
  - io_oeb=all 1s (all pads inputs), user_irq=0.
  - All registers 0 except OEB. Synchronizer and edge flops reset to 0.
- Hit: cyc&stb&(adr[31:8]==BASE_ADR[31:8]). adr[1:0] is ignored. Offset = adr[7:2].
- Non-hit: no ack, no state change. The bus times out upstream.
- Register map (byte offset):
  - 0x00 OUT_LO, RW, 32 bits, io_out[31:0].
  - 0x04 OUT_HI, RW, bits[5:0], io_out[37:32].
  - 0x08 OEB_LO, RW, reset FFFF_FFFF.
  - 0x0C OEB_HI, RW, bits[5:0], reset 3F.
  - 0x10 IN_LO, RO, synchronized io_in[31:0].
  - 0x14 IN_HI, RO, bits[5:0].
  - 0x18 STAT, W1C, rising-edge flags for io_in[31:0].
  - 0x1C IRQ_EN, RW, 32 bits.
  - Other offsets in the window: read 0, writes ignored, still acked.
  - Unused high bits read 0.
- FSM states: IDLE, ACK.
  - IDLE and hit: go to ACK. On the same edge, wbs_ack_o becomes 1.
  - For a write, data commits on that edge, per byte lane where sel=1.
  - For a read, wbs_dat_o is registered on that edge.
  - ACK: wbs_ack_o returns to 0 on the next edge and the state returns to IDLE, whether or not stb is still high.
  - Result: one-cycle ack pulse, single-cycle latency, and at most one transfer every 2 cycles.
  - After the ack cycle, wbs_dat_o holds its last value. Only ack qualifies it.
- Writes with sel=0000 are acked with no effect.
- Input path:
  - io_in passes through SYNC_STAGES flops to give `sync`, then one flop to give `prev`.
  - rise[i] = sync[i] & ~prev[i] sets STAT[i].
  - Pins held high through reset produce a STAT bit SYNC_STAGES+1 cycles after reset release. This is intended.
- STAT update: STAT <= (STAT & ~(W1C mask)) | rise. Set wins when a write-clear and a new edge hit the same bit in the same cycle. The W1C mask is written data masked by sel lanes.
- IRQ: user_irq[0] is registered, = |(STAT & IRQ_EN), one cycle after STAT/IRQ_EN update. user_irq[2:1] = 0.
- io_out and io_oeb are driven directly from the registers, so a write is visible at the pins on the ack edge.
- Reset asserted mid-transaction: the next edge forces IDLE, ack=0 and reset values. The in-flight write is lost.

Decomposition:
- Package gpio_regs_pkg holds:
  - offset constants OFS_OUT_LO..OFS_IRQ_EN;
  - N_IO=38 and N_HI=6;
  - the FSM state enum wb_state_t {IDLE, ACK};
  - OEB reset constants.
- One sub-module, gpio_in_sync: parameterized-width multi-stage synchronizer plus prev flop, outputting sync and rise.
- Bus FSM, register file and irq logic stay in the top module.

Test Plan:
- Reset: assert wb_rst_i 3 cycles -> io_oeb=38'h3F_FFFF_FFFF, io_out=0, ack=0, user_irq=0. Read 0x08 -> FFFF_FFFF. Read 0x1C -> 0.
- Byte-lane write: write 0x00 data A5A5_A5A5 sel=0101 -> read 0x00 = 00A5_00A5. io_out[31:0] = 00A5_00A5 on the ack edge. Ack is high exactly 1 cycle with stb held 3 cycles.
- Address decode:
  - write 0x3000_0100 (outside the window) -> no ack within 16 cycles, registers unchanged;
  - write 0x3000_0040 -> acked, reads back 0;
  - write 0x04 data FFFF_FFFF -> reads back 0000_003F.
- Input sync and edge: drive io_in[3] 0->1 -> IN_LO bit3 reads 1 and STAT=0000_0008 after 3 cycles. Enable IRQ_EN=8 -> user_irq[0]=1 one cycle later. Write STAT=8 -> user_irq[0]=0.
- Clear/set collision: STAT bit5 set, then write STAT=0x20 on the same edge io_in[5] rises again (sync/prev timed) -> STAT bit5 stays 1.
- Reset mid-transaction: stb/cyc write 0x00 data 1234_5678, assert reset the cycle before the ack edge -> no ack, OUT_LO=0. A subsequent read of 0x00 -> 0.
